// File: rtl/hdmi_palette_sync.sv
// HDMI back end: NES palette lookup, colour emphasis, border fill and sync
// generation, with every output two clk_h cycles after its hx/hy sample.
module hdmi_palette_sync #(
    parameter int          H_ACTIVE     = 720,
    parameter int          V_ACTIVE     = 480,
    parameter int          H_SYNC_START = 736,
    parameter int          H_SYNC_LEN   = 62,
    parameter int          V_SYNC_START = 489,
    parameter int          V_SYNC_LEN   = 6,
    parameter logic        SYNC_POL     = 1'b0,
    parameter logic [23:0] BORDER_RGB   = 24'h000000,
    parameter int          PIXEL_DEPTH  = 6
) (
    input  logic                   clk_h,
    input  logic                   rst_h_n,
    input  logic [9:0]             hx,
    input  logic [9:0]             hy,
    input  logic [PIXEL_DEPTH-1:0] pixel_h,
    input  logic                   nes_on,
    input  logic [2:0]             emph,
    input  logic                   pal_wr_en,
    input  logic [PIXEL_DEPTH-1:0] pal_wr_addr,
    input  logic [23:0]            pal_wr_data,
    output logic [23:0]            rgb,
    output logic                   hsync,
    output logic                   vsync,
    output logic                   de
);

    localparam int NPAL = 1 << PIXEL_DEPTH;

    localparam logic [9:0] HA  = 10'(H_ACTIVE);
    localparam logic [9:0] VA  = 10'(V_ACTIVE);
    localparam logic [9:0] HS0 = 10'(H_SYNC_START);
    localparam logic [9:0] HS1 = 10'(H_SYNC_START + H_SYNC_LEN);
    localparam logic [9:0] VS0 = 10'(V_SYNC_START);
    localparam logic [9:0] VS1 = 10'(V_SYNC_START + V_SYNC_LEN);

    localparam logic [23:0] PAL_DEF [0:63] = '{
        24'h666666, 24'h002A88, 24'h1412A7, 24'h3B00A4,
        24'h5C007E, 24'h6E0040, 24'h6C0600, 24'h561D00,
        24'h333500, 24'h0B4800, 24'h005200, 24'h004F08,
        24'h00404D, 24'h000000, 24'h000000, 24'h000000,
        24'hADADAD, 24'h155FD9, 24'h4240FF, 24'h7527FE,
        24'hA01ACC, 24'hB71E7B, 24'hB53120, 24'h994E00,
        24'h6B6D00, 24'h388700, 24'h0C9300, 24'h008F32,
        24'h007C8D, 24'h000000, 24'h000000, 24'h000000,
        24'hFFFEFF, 24'h64B0FF, 24'h9290FF, 24'hC676FF,
        24'hF36AFF, 24'hFE6ECC, 24'hFE8170, 24'hEA9E22,
        24'hBCBE00, 24'h88D800, 24'h5CE430, 24'h45E082,
        24'h48CDDE, 24'h4F4F4F, 24'h000000, 24'h000000,
        24'hFFFEFF, 24'hC0DFFF, 24'hD3D2FF, 24'hE8C8FF,
        24'hFBC2FF, 24'hFEC4EA, 24'hFECCC5, 24'hF7D8A5,
        24'hE4E594, 24'hCFEF96, 24'hBDF4AB, 24'hB3F3CC,
        24'hB5EBF2, 24'hB8B8B8, 24'h000000, 24'h000000
    };

    typedef struct packed {
        logic        de;
        logic        hs;
        logic        vs;
        logic        nes;
        logic [2:0]  emph;
        logic [23:0] pal;
    } s1_t;

    logic [23:0] pal [0:NPAL-1];
    s1_t         s1;
    logic [23:0] emph_rgb;

    function automatic logic [7:0] dim(input logic [7:0] c);
        return c - {2'b00, c[7:2]};
    endfunction

    // Palette flops: reset reloads the default table, writes land at the edge
    always_ff @(posedge clk_h) begin
        if (!rst_h_n) begin
            for (int i = 0; i < NPAL; i++) begin
                pal[i] <= PAL_DEF[i];
            end
        end else if (pal_wr_en) begin
            pal[pal_wr_addr] <= pal_wr_data;
        end
    end

    always_ff @(posedge clk_h) begin
        if (!rst_h_n) begin
            s1 <= '0;
        end else begin
            s1.de   <= (hx < HA) && (hy < VA);
            s1.hs   <= (hx >= HS0) && (hx < HS1);
            s1.vs   <= (hy >= VS0) && (hy < VS1);
            s1.nes  <= nes_on;
            s1.emph <= emph;
            s1.pal  <= pal[pixel_h];
        end
    end

    // Channels whose emphasis bit is clear are dimmed to 3/4
    always_comb begin
        emph_rgb = s1.pal;
        if (s1.emph != 3'b000) begin
            emph_rgb[23:16] = s1.emph[0] ? s1.pal[23:16] : dim(s1.pal[23:16]);
            emph_rgb[15:8]  = s1.emph[1] ? s1.pal[15:8]  : dim(s1.pal[15:8]);
            emph_rgb[7:0]   = s1.emph[2] ? s1.pal[7:0]   : dim(s1.pal[7:0]);
        end
    end

    always_ff @(posedge clk_h) begin
        if (!rst_h_n) begin
            rgb   <= '0;
            de    <= 1'b0;
            hsync <= ~SYNC_POL;
            vsync <= ~SYNC_POL;
        end else begin
            rgb   <= !s1.de ? 24'h0 : !s1.nes ? BORDER_RGB : emph_rgb;
            de    <= s1.de;
            hsync <= s1.hs ? SYNC_POL : ~SYNC_POL;
            vsync <= s1.vs ? SYNC_POL : ~SYNC_POL;
        end
    end

endmodule
